// File: rtl/lfsr_pkg.sv
// lfsr_pkg: FSM encoding, common tap masks and a default maximal-length tap table
// shared by lfsr_core and lfsr_gen.
package lfsr_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } lfsr_gen_state_e;

    localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

    // Bit i set means state[i] feeds the XOR; 0 for widths outside 3..32.
    function automatic logic [31:0] lfsr_default_taps(input int width);
        case (width)
            3:       lfsr_default_taps = 32'h0000_0006;
            4:       lfsr_default_taps = 32'h0000_000C;
            5:       lfsr_default_taps = 32'h0000_0014;
            6:       lfsr_default_taps = 32'h0000_0030;
            7:       lfsr_default_taps = 32'h0000_0060;
            8:       lfsr_default_taps = 32'h0000_00B8;
            9:       lfsr_default_taps = 32'h0000_0110;
            10:      lfsr_default_taps = 32'h0000_0240;
            11:      lfsr_default_taps = 32'h0000_0500;
            12:      lfsr_default_taps = 32'h0000_0829;
            13:      lfsr_default_taps = 32'h0000_100D;
            14:      lfsr_default_taps = 32'h0000_2015;
            15:      lfsr_default_taps = 32'h0000_6000;
            16:      lfsr_default_taps = 32'h0000_B400;
            17:      lfsr_default_taps = 32'h0001_2000;
            18:      lfsr_default_taps = 32'h0002_0400;
            19:      lfsr_default_taps = 32'h0004_0023;
            20:      lfsr_default_taps = 32'h0009_0000;
            21:      lfsr_default_taps = 32'h0014_0000;
            22:      lfsr_default_taps = 32'h0030_0000;
            23:      lfsr_default_taps = 32'h0042_0000;
            24:      lfsr_default_taps = 32'h00E1_0000;
            25:      lfsr_default_taps = 32'h0120_0000;
            26:      lfsr_default_taps = 32'h0200_0023;
            27:      lfsr_default_taps = 32'h0400_0013;
            28:      lfsr_default_taps = 32'h0900_0000;
            29:      lfsr_default_taps = 32'h1400_0000;
            30:      lfsr_default_taps = 32'h2000_0029;
            31:      lfsr_default_taps = 32'h4800_0000;
            32:      lfsr_default_taps = 32'h8020_0003;
            default: lfsr_default_taps = 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: Fibonacci LFSR register. A zero seed is loaded as 1 so the
// all-zero lockup state can never be entered.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_default_taps(WIDTH))
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] state_o,
    output logic [WIDTH-1:0] step_val_o,
    output logic [WIDTH-1:0] load_val_o,
    output logic             out_bit_o
);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] step_val;

    always_comb begin
        load_val = (seed_i == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : seed_i;
        step_val = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
        state_d  = state_q;
        if (load_i) begin
            state_d = load_val;
        end else if (step_i) begin
            state_d = step_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= '1;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o    = state_q;
    assign step_val_o = step_val;
    assign load_val_o = load_val;
    assign out_bit_o  = state_q[WIDTH-1];

endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: packs LFSR output bits into OUT_BITS words offered on valid/ready.
// Define LFSR_GEN_PERIOD_EN to enable the period_wrap_o sequence-wrap detector.
//   state | meaning
//   FILL  | shifting LFSR bits into the word while en_i is high
//   HOLD  | complete word offered, LFSR frozen until accepted
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(lfsr_default_taps(WIDTH)),
    parameter int unsigned      OUT_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                seed_load_i,
    input  logic [WIDTH-1:0]    seed_i,
    input  logic                en_i,
    output logic [OUT_BITS-1:0] word_o,
    output logic                word_valid_o,
    input  logic                word_ready_i,
    output logic [WIDTH-1:0]    state_o,
    output logic                period_wrap_o
);

    localparam int unsigned CNT_W  = $clog2(OUT_BITS + 1);
    localparam logic [0:0]  S_FILL = FILL;
    localparam logic [0:0]  S_HOLD = HOLD;

    logic [0:0]          fsm_q, fsm_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OUT_BITS-1:0] word_q, word_d;
    logic                step;
    logic                out_bit;
    logic [WIDTH-1:0]    step_val;
    logic [WIDTH-1:0]    load_val;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (seed_load_i),
        .seed_i     (seed_i),
        .step_i     (step),
        .state_o    (state_o),
        .step_val_o (step_val),
        .load_val_o (load_val),
        .out_bit_o  (out_bit)
    );

    always_comb begin
        step   = 1'b0;
        fsm_d  = fsm_q;
        cnt_d  = cnt_q;
        word_d = word_q;
        if (seed_load_i) begin
            fsm_d  = S_FILL;
            cnt_d  = '0;
            word_d = '0;
        end else begin
            case (fsm_q)
                S_FILL: begin
                    if (en_i) begin
                        step   = 1'b1;
                        word_d = (word_q << 1) | OUT_BITS'(out_bit);
                        if (cnt_q == CNT_W'(OUT_BITS - 1)) begin
                            cnt_d = '0;
                            fsm_d = S_HOLD;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (word_ready_i) begin
                        fsm_d = S_FILL;
                    end
                end
                default: fsm_d = S_FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q  <= S_FILL;
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = (fsm_q == S_HOLD);

`ifdef LFSR_GEN_PERIOD_EN
    logic [WIDTH-1:0] ref_q;
    logic             wrap_q;

    // Reference tracks the effective start state: all ones after reset, else the last load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ref_q  <= '1;
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= step && (step_val == ref_q);
            if (seed_load_i) begin
                ref_q <= load_val;
            end
        end
    end

    assign period_wrap_o = wrap_q;
`else
    logic unused_period;
    assign unused_period = ^{step_val, load_val};
    assign period_wrap_o = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed checks plus a randomized scoreboard run of lfsr_gen
// against a bit-stream reference model, WIDTH=8 with taps 8'hB8.
module tb_lfsr_gen;
    import lfsr_pkg::*;

    localparam logic [7:0] TAPS = LFSR_TAPS_8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       ld4, en4, rdy4, v4, pw4;
    logic [7:0] seed4, st4;
    logic [3:0] word4;
    logic       ld1, en1, rdy1, v1, pw1;
    logic [7:0] seed1, st1;
    logic [0:0] word1;

    int n_cmp = 0;
    int n_err = 0;
    int n_pop = 0;

    typedef struct packed {
        logic [3:0] word;
        logic [7:0] state;
    } exp_t;
    exp_t       q[$];
    logic       scb_on = 1'b0;
    logic [7:0] m_s;

    lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .OUT_BITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .seed_load_i(ld4), .seed_i(seed4), .en_i(en4),
        .word_o(word4), .word_valid_o(v4), .word_ready_i(rdy4), .state_o(st4),
        .period_wrap_o(pw4)
    );

    lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .OUT_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .seed_load_i(ld1), .seed_i(seed1), .en_i(en1),
        .word_o(word1), .word_valid_o(v1), .word_ready_i(rdy1), .state_o(st1),
        .period_wrap_o(pw1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: next LFSR value from the tap parity, in plain arithmetic.
    function automatic logic [7:0] nxt(input logic [7:0] s);
        int fb;
        fb  = $countones(s & TAPS) % 2;
        nxt = 8'((int'(s) * 2 + fb) % 256);
    endfunction

    // Four output bits (old MSB each step) starting from s_in.
    task automatic gen_word(input logic [7:0] s_in, output logic [3:0] w, output logic [7:0] s_out);
        int acc;
        logic [7:0] s;
        acc = 0;
        s   = s_in;
        for (int k = 0; k < 4; k++) begin
            acc = acc * 2 + int'(s) / 128;
            s   = nxt(s);
        end
        w     = 4'(acc);
        s_out = s;
    endtask

    task automatic push_ahead();
        logic [3:0] w;
        logic [7:0] s2;
        while (q.size() < 4) begin
            gen_word(m_s, w, s2);
            q.push_back('{word: w, state: s2});
            m_s = s2;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic prev_v = 1'b0, prev_hs = 1'b0, prev_ld = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (scb_on) begin
            if (prev_v && !v4) check("valid_drop_cause", 32'(prev_hs | prev_ld), 32'd1);
            if (v4 && rdy4 && !ld4) begin
                check("scb_queue_nonempty", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("scb_word", 32'(word4), 32'(e.word));
                    check("scb_state", 32'(st4), 32'(e.state));
                    n_pop++;
                end
            end
        end
        prev_v  <= v4;
        prev_hs <= v4 && rdy4 && !ld4;
        prev_ld <= ld4;
    end

    initial begin
        logic [7:0] s, prev, ps;
        logic [3:0] w;
        logic       exp_pw;
        int         n, steps, pulses, pulse_step;

        rst_n = 1'b0;
        ld4 = 1'b0; en4 = 1'b0; rdy4 = 1'b0; seed4 = 8'h00;
        ld1 = 1'b0; en1 = 1'b0; rdy1 = 1'b0; seed1 = 8'h00;
        tick();
        tick();
        check("rst_state", 32'(st4), 32'hFF);
        check("rst_valid", 32'(v4), 32'd0);
        check("rst_word", 32'(word4), 32'd0);
        check("rst_wrap", 32'(pw4), 32'd0);

        // Fill from reset state, no consumer.
        rst_n = 1'b1; en4 = 1'b1;
        s = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            s = nxt(s);
            check("t1_state", 32'(st4), 32'(s));
            check("t1_valid", 32'(v4), 32'(i == 3));
        end
        check("t1_word", 32'(word4), 32'hF);
        check("t1_state_f0", 32'(st4), 32'hF0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t1_hold_state", 32'(st4), 32'(s));
            check("t1_hold_valid", 32'(v4), 32'd1);
        end

        // One-cycle accept, then the next word.
        rdy4 = 1'b1;
        tick();
        rdy4 = 1'b0;
        check("t2_valid_fall", 32'(v4), 32'd0);
        check("t2_no_step", 32'(st4), 32'(s));
        gen_word(s, w, ps);
        for (int i = 0; i < 4; i++) begin
            tick();
            s = nxt(s);
            check("t2_state", 32'(st4), 32'(s));
        end
        check("t2_word", 32'(word4), 32'(w));
        check("t2_valid", 32'(v4), 32'd1);

        // Zero seed substitution, then load during HOLD.
        ld4 = 1'b1; seed4 = 8'h00;
        tick();
        ld4 = 1'b0;
        check("t3_zero_seed", 32'(st4), 32'h01);
        check("t3_valid", 32'(v4), 32'd0);
        tick();
        check("t3_first_step", 32'(st4), 32'h02);
        tick(); tick(); tick();
        check("t3_full", 32'(v4), 32'd1);
        ld4 = 1'b1; seed4 = 8'hA5;
        tick();
        ld4 = 1'b0; en4 = 1'b0;
        check("t3_hold_load_valid", 32'(v4), 32'd0);
        check("t3_hold_load_word", 32'(word4), 32'd0);
        check("t3_hold_load_state", 32'(st4), 32'hA5);

        // en toggling: same sequence, valid after the 4th enabled cycle.
        s = 8'hA5;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            en4 = (i % 2 == 0);
            tick();
            if (en4 && n < 4) begin
                n++;
                s = nxt(s);
            end
            check("t4_state", 32'(st4), 32'(s));
            check("t4_valid", 32'(v4), 32'(n == 4));
        end
        gen_word(8'hA5, w, ps);
        check("t4_word", 32'(word4), 32'(w));
        check("t4_state_vs_en1", 32'(st4), 32'(ps));

        // seed_load and word_ready together in HOLD: the load wins.
        ld4 = 1'b1; seed4 = 8'h3C; rdy4 = 1'b1; en4 = 1'b1;
        tick();
        ld4 = 1'b0; rdy4 = 1'b0;
        check("t6_valid", 32'(v4), 32'd0);
        check("t6_state", 32'(st4), 32'h3C);
        check("t6_word", 32'(word4), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_latency", 32'(v4), 32'(i == 3));
        end
        gen_word(8'h3C, w, ps);
        check("t6_fresh_word", 32'(word4), 32'(w));
        check("t6_fresh_state", 32'(st4), 32'(ps));

        // Randomized scoreboard run.
        scb_on = 1'b1;
        for (int i = 0; i < 800; i++) begin
            en4  = ($urandom_range(3) != 0);
            rdy4 = 1'($urandom_range(1));
            ld4  = (i == 0) || ($urandom_range(49) == 0);
            if (ld4) begin
                seed4 = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
                q.delete();
                m_s = (seed4 == 8'h00) ? 8'h01 : seed4;
            end
            push_ahead();
            tick();
        end
        ld4 = 1'b0; en4 = 1'b0; rdy4 = 1'b0;
        tick();
        scb_on = 1'b0;
        check("scb_words_seen", 32'(n_pop > 20), 32'd1);

        // Full period with OUT_BITS=1 from reset.
        rst_n = 1'b0;
        tick();
        tick();
        check("p_rst_state", 32'(st1), 32'hFF);
        check("p_rst_wrap", 32'(pw1), 32'd0);
        rst_n = 1'b1; en1 = 1'b1; rdy1 = 1'b1;
        prev = 8'hFF;
        steps = 0; pulses = 0; pulse_step = 0;
        for (int i = 0; i < 530; i++) begin
            tick();
            exp_pw = 1'b0;
            if (st1 != prev) begin
                steps++;
                check("p_state", 32'(st1), 32'(nxt(prev)));
                check("p_word", 32'(word1), 32'(prev[7]));
`ifdef LFSR_GEN_PERIOD_EN
                exp_pw = (st1 == 8'hFF);
`endif
            end
            check("p_wrap", 32'(pw1), 32'(exp_pw));
            if (pw1) begin
                pulses++;
                pulse_step = steps;
            end
            prev = st1;
        end
`ifdef LFSR_GEN_PERIOD_EN
        check("p_wrap_count", 32'(pulses), 32'd1);
        check("p_wrap_step", 32'(pulse_step), 32'd255);
`else
        check("p_wrap_count", 32'(pulses), 32'd0);
`endif
        check("p_steps", 32'(steps), 32'd265);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
